// File: rtl/seq_detect_pkg.sv
// Shared types and the 1011 detector next-state function used by every
// channel of the time-shared sequence detector.
package seq_detect_pkg;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } det_state_t;

    localparam det_state_t DET_HIT = S4;

    // Overlapping Moore detector: S4 behaves like S1 for the next bit
    // because the trailing 1 of 1011 can start a new match.
    function automatic det_state_t det_next(input det_state_t st, input logic b);
        det_state_t nxt;
        case (st)
            S0:      nxt = b ? S1 : S0;
            S1:      nxt = b ? S1 : S2;
            S2:      nxt = b ? S3 : S0;
            S3:      nxt = b ? S4 : S2;
            S4:      nxt = b ? S1 : S2;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts one past the
// most recently granted channel and wraps around.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         elig,
    input  logic [$clog2(N)-1:0] last,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic w_found;
    int   w_cand;

    always_comb begin
        gnt     = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = int'(last) + 1 + k;
            if (w_cand >= N) begin
                w_cand = w_cand - N;
            end
            if (!w_found && elig[w_cand]) begin
                w_found     = 1'b1;
                gnt[w_cand] = 1'b1;
                idx         = IW'(w_cand);
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one 1011 detector datapath among NCH serial
// channels, with per-channel saved state and saturating hit counters.
import seq_detect_pkg::*;

module seq_detect_sched #(
    parameter int NCH = 4,
    parameter int CW  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         bit_in,
    input  logic [NCH-1:0]         clr_ch,
    output logic [NCH-1:0]         gnt,
    output logic                   det_valid,
    output logic [$clog2(NCH)-1:0] det_ch,
    input  logic [$clog2(NCH)-1:0] rd_sel,
    output logic [CW-1:0]          hit_cnt
);

    localparam int IW = $clog2(NCH);

    det_state_t      r_st  [NCH];
    logic [CW-1:0]   r_cnt [NCH];
    logic [IW-1:0]   r_last;
    logic            r_det_valid;
    logic [IW-1:0]   r_det_ch;

    logic [NCH-1:0]  w_elig;
    logic [NCH-1:0]  w_gnt;
    logic [IW-1:0]   w_idx;
    logic            w_any;
    det_state_t      w_next;
    logic            w_hit;

    // A channel being cleared is withheld from arbitration, and nothing is
    // granted while reset is held.
    assign w_elig = req & ~clr_ch & {NCH{~reset}};

    rr_arbiter #(.N(NCH)) u_arb (
        .elig (w_elig),
        .last (r_last),
        .gnt  (w_gnt),
        .idx  (w_idx)
    );

    assign w_any  = |w_gnt;
    assign w_next = det_next(r_st[w_idx], bit_in[w_idx]);
    assign w_hit  = w_any && (w_next == DET_HIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                r_st[i]  <= S0;
                r_cnt[i] <= '0;
            end
            r_last      <= IW'(NCH - 1);
            r_det_valid <= 1'b0;
            r_det_ch    <= '0;
        end else begin
            r_det_valid <= w_hit;
            if (w_hit) begin
                r_det_ch <= w_idx;
            end
            if (w_any) begin
                r_last <= w_idx;
            end
            for (int i = 0; i < NCH; i++) begin
                if (clr_ch[i]) begin
                    r_st[i]  <= S0;
                    r_cnt[i] <= '0;
                end else if (w_gnt[i]) begin
                    r_st[i] <= w_next;
                    if ((w_next == DET_HIT) && (r_cnt[i] != {CW{1'b1}})) begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign gnt       = w_gnt;
    assign det_valid = r_det_valid;
    assign det_ch    = r_det_ch;
    assign hit_cnt   = r_cnt[rd_sel];

endmodule

// File: tb/tb_seq_detect_sched.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run, all compared against a bit-history reference model.
module tb_seq_detect_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req, bitIn, clrCh, gnt;
    logic       detValid;
    logic [1:0] detCh, rdSel;
    logic [7:0] hitCnt;

    logic [3:0] satReq, satBit, satClr, satGnt;
    logic       satValid;
    logic [1:0] satCh, satSel;
    logic [1:0] satCnt;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: last four accepted bits per channel; a hit is those
    // four bits reading 1011.
    logic [3:0] mHist [4];
    int         mCnt  [4];
    int         mLast;
    logic       mDv;
    int         mDch;

    typedef struct {
        logic [3:0] vReq;
        logic [3:0] vBits;
        logic [3:0] eGnt;
        logic       eDv;
        logic [1:0] eDch;
        logic [7:0] eCnt;
    } vec_t;

    vec_t tbl [9];

    seq_detect_sched #(.NCH(4), .CW(8)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .bit_in    (bitIn),
        .clr_ch    (clrCh),
        .gnt       (gnt),
        .det_valid (detValid),
        .det_ch    (detCh),
        .rd_sel    (rdSel),
        .hit_cnt   (hitCnt)
    );

    seq_detect_sched #(.NCH(4), .CW(2)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .req       (satReq),
        .bit_in    (satBit),
        .clr_ch    (satClr),
        .gnt       (satGnt),
        .det_valid (satValid),
        .det_ch    (satCh),
        .rd_sel    (satSel),
        .hit_cnt   (satCnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] modelGnt(input logic [3:0] e);
        int c;
        for (int k = 1; k <= 4; k++) begin
            c = (mLast + k) % 4;
            if (e[c]) return 4'(1 << c);
        end
        return 4'b0000;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mHist[i] = 4'b0000;
            mCnt[i]  = 0;
        end
        mLast = 3;
        mDv   = 1'b0;
        mDch  = 0;
    endtask

    task automatic modelStep(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
        logic [3:0] g;
        logic       hit;
        g   = modelGnt(r & ~c);
        hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                mHist[i] = 4'b0000;
                mCnt[i]  = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                mHist[i] = {mHist[i][2:0], b[i]};
                mLast    = i;
                if (mHist[i] == 4'b1011) begin
                    hit  = 1'b1;
                    mDch = i;
                    if (mCnt[i] < 255) mCnt[i] = mCnt[i] + 1;
                end
            end
        end
        mDv = hit;
    endtask

    // Drives one cycle's inputs and checks outputs mid-cycle against the model.
    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] b,
                                 input logic [3:0] c, input logic [1:0] rs);
        req   = r;
        bitIn = b;
        clrCh = c;
        rdSel = rs;
        #3;
        checkOutput("gnt", 32'(gnt), 32'(modelGnt(r & ~c)));
        checkOutput("det_valid", 32'(detValid), 32'(mDv));
        checkOutput("det_ch", 32'(detCh), 32'(mDch));
        checkOutput("hit_cnt", 32'(hitCnt), 32'(mCnt[rs]));
    endtask

    task automatic finishCycle();
        modelStep(req, bitIn, clrCh);
        @(posedge clk);
        #1;
    endtask

    task automatic runCycle(input logic [3:0] r, input logic [3:0] b,
                            input logic [3:0] c, input logic [1:0] rs);
        applyStimulus(r, b, c, rs);
        finishCycle();
    endtask

    // Pulses the asynchronous reset between clock edges.
    task automatic doReset(input logic [3:0] r, input logic [3:0] b);
        req   = r;
        bitIn = b;
        clrCh = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_det_valid", 32'(detValid), 32'h0);
        checkOutput("rst_hit_cnt", 32'(hitCnt), 32'h0);
        req   = 4'b0000;
        bitIn = 4'b0000;
        #1;
        reset = 1'b0;
        modelReset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        logic [3:0] rr, bb, cc;
        logic [1:0] rs;
        pat = 4'b1011;

        tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'd0};
        tbl[1] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd0};
        tbl[2] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'd0};
        tbl[3] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'd0};
        tbl[4] = '{4'b0001, 4'b0000, 4'b0001, 1'b1, 2'd0, 8'd1};
        tbl[5] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'd1};
        tbl[6] = '{4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0, 8'd1};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd2};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 8'd2};

        reset  = 1'b1;
        req    = '0; bitIn  = '0; clrCh = '0; rdSel  = '0;
        satReq = '0; satBit = '0; satClr = '0; satSel = '0;
        modelReset();
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] saturating counter, CW=2");
        for (int j = 0; j < 5; j++) begin
            for (int t = 0; t < 4; t++) begin
                satReq = 4'b0001;
                satBit = {3'b000, pat[3-t]};
                @(posedge clk);
                #1;
            end
            satReq = 4'b0000;
            satBit = 4'b0000;
            #3;
            checkOutput("sat_det_valid", 32'(satValid), 32'h1);
            checkOutput("sat_det_ch", 32'(satCh), 32'h0);
            checkOutput("sat_hit_cnt", 32'(satCnt), (j < 3) ? 32'(j + 1) : 32'h3);
            @(posedge clk);
            #1;
        end

        $display("[TB] directed table on channel 0");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(tbl[k].vReq, tbl[k].vBits, 4'b0000, 2'd0);
            checkOutput("tbl_gnt", 32'(gnt), 32'(tbl[k].eGnt));
            checkOutput("tbl_det_valid", 32'(detValid), 32'(tbl[k].eDv));
            checkOutput("tbl_det_ch", 32'(detCh), 32'(tbl[k].eDch));
            checkOutput("tbl_hit_cnt", 32'(hitCnt), 32'(tbl[k].eCnt));
            finishCycle();
        end

        $display("[TB] fairness with all channels requesting");
        doReset(4'b0000, 4'b0000);
        for (int k = 0; k < 16; k++) begin
            applyStimulus(4'b1111, {1'b0, pat[3-(k/4)], 2'b00}, 4'b0000, 2'd2);
            checkOutput("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
            if (k == 15) checkOutput("rr_det_valid", 32'(detValid), 32'h1);
            finishCycle();
        end
        for (int i = 0; i < 4; i++) runCycle(4'b0000, 4'b0000, 4'b0000, 2'(i));

        $display("[TB] clear on channel 1");
        doReset(4'b0000, 4'b0000);
        runCycle(4'b0010, 4'b0010, 4'b0000, 2'd1);
        runCycle(4'b0010, 4'b0000, 4'b0000, 2'd1);
        runCycle(4'b0010, 4'b0010, 4'b0000, 2'd1);
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 2'd1);
        checkOutput("clr_gnt", 32'(gnt), 32'h0);
        finishCycle();
        runCycle(4'b0010, 4'b0010, 4'b0000, 2'd1);
        runCycle(4'b0010, 4'b0000, 4'b0000, 2'd1);
        runCycle(4'b0010, 4'b0010, 4'b0000, 2'd1);
        runCycle(4'b0010, 4'b0010, 4'b0000, 2'd1);
        runCycle(4'b0000, 4'b0000, 4'b0000, 2'd1);

        $display("[TB] reset mid-stream on channel 3");
        runCycle(4'b1000, 4'b1000, 4'b0000, 2'd3);
        runCycle(4'b1000, 4'b0000, 4'b0000, 2'd3);
        runCycle(4'b1000, 4'b1000, 4'b0000, 2'd3);
        doReset(4'b1000, 4'b1000);
        runCycle(4'b1000, 4'b1000, 4'b0000, 2'd3);
        runCycle(4'b1000, 4'b0000, 4'b0000, 2'd3);
        runCycle(4'b1000, 4'b1000, 4'b0000, 2'd3);
        runCycle(4'b1000, 4'b1000, 4'b0000, 2'd3);
        runCycle(4'b0000, 4'b0000, 4'b0000, 2'd3);

        $display("[TB] channels 1 and 3 alternating");
        doReset(4'b0000, 4'b0000);
        runCycle(4'b0010, 4'b0000, 4'b0000, 2'd0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b1010, 4'b0000, 4'b0000, 2'd0);
            checkOutput("alt_gnt", 32'(gnt), (k % 2 == 0) ? 32'h8 : 32'h2);
            finishCycle();
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            rr = 4'($urandom);
            bb = 4'($urandom);
            cc = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(15) == 0) cc[i] = 1'b1;
            end
            rs = 2'($urandom_range(3));
            runCycle(rr, bb, cc, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
